kronos_dmem: RTL



---
 rtl/kronos_types.sv | 12 +
 rtl/kronos_spram.sv | 29 ++
 rtl/kronos_dmem.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/kronos_types.sv
// Shared types and constants for the kronos data-side blocks.
package kronos_types;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GRANT
  } dmem_state_e;

  localparam int unsigned DMEM_MAX_WAIT = 15;

endpackage

// File: rtl/kronos_spram.sv
// Single-port RAM with byte write enables and registered read data.
// The read register only updates on read cycles, so it holds across writes.
module kronos_spram #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  input  logic [3:0]               be,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/kronos_dmem.sv
// Data memory responder: held-request / single-pulse-grant handshake in front
// of a byte-maskable word RAM, with a fixed number of wait states.
module kronos_dmem
  import kronos_types::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_wr_mask,
  input  logic        data_rd_req,
  input  logic        data_wr_req,
  output logic [31:0] data_rd_data,
  output logic        data_gnt,
  output logic        data_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] CntInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("kronos_dmem: DEPTH must be a power of two");
  end
  if (WAIT_CYCLES > DMEM_MAX_WAIT) begin : g_bad_wait
    $error("kronos_dmem: WAIT_CYCLES exceeds DMEM_MAX_WAIT");
  end

  dmem_state_e   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    mask_q;
  logic          wr_q, rd_q, err_q, rd_ok_q;
  logic          capture;

  logic          req;
  logic [31:0]   req_off;
  logic          req_ok;
  logic [AW-1:0] req_idx;

  assign req     = data_rd_req | data_wr_req;
  assign req_off = data_addr - BASE_ADDR;
  // Wrapped offset: addresses below BASE_ADDR land far above the window.
  assign req_ok  = {1'b0, req_off} < (33'(DEPTH) << 2);
  assign req_idx = req_off[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CntInit;
          end else begin
            state_d = GRANT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = GRANT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GRANT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      mask_q  <= 4'h0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        idx_q   <= req_idx;
        wdata_q <= data_wr_data;
        mask_q  <= data_wr_mask;
        wr_q    <= data_wr_req;
        rd_q    <= data_rd_req;
        err_q   <= ~req_ok;
      end
    end
  end

  // With no wait states the read is issued straight from the live request.
  logic          from_idle, cur_rd, cur_ok, enter_grant;
  logic          ram_re, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;

  assign from_idle   = (state_q == IDLE);
  assign cur_rd      = from_idle ? data_rd_req : rd_q;
  assign cur_ok      = from_idle ? req_ok : ~err_q;
  assign ram_addr    = from_idle ? req_idx : idx_q;
  assign enter_grant = (state_d == GRANT);
  assign ram_re      = enter_grant & cur_rd & cur_ok;
  assign ram_we      = (state_q == GRANT) & wr_q & ~err_q;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      rd_ok_q <= 1'b0;
    end else if (enter_grant && cur_rd) begin
      rd_ok_q <= cur_ok;
    end
  end

  kronos_spram #(
    .DEPTH (DEPTH)
  ) u_spram (
    .clk   (clk),
    .en    (ram_re | ram_we),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .be    (mask_q),
    .rdata (ram_rdata)
  );

  assign data_gnt     = (state_q == GRANT);
  assign data_err     = data_gnt & err_q;
  assign data_rd_data = rd_ok_q ? ram_rdata : 32'h0;

endmodule
